// File: rtl/md_ctrl_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
package md_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int MD_CNT_W           = 6;
  localparam int MD_TIMEOUT_DEFAULT = 40;

endpackage

// File: rtl/md_cycle_counter.sv
// Saturating busy-cycle counter with synchronous clear and count enable.
module md_cycle_counter
  import md_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  output logic [MD_CNT_W-1:0] cnt
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + MD_CNT_W'(1);
    end
  end

endmodule

// File: rtl/md_issue_ctrl.sv
// Sequences the shared mult/div unit: issues the start pulse, stalls F/D and D/X while
// it runs and injects its result into X/M. Define MD_TIMEOUT_EN to enable the watchdog.
//
// state | meaning
// IDLE  | waiting for a mult/div in D/X; issues and stalls in the same cycle
// BUSY  | unit running, pipeline frozen, waiting for md_ready
// DONE  | one cycle: result injected into X/M, stall released
module md_issue_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = MD_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dx_valid,
  input  logic              dx_is_mult,
  input  logic              dx_is_div,
  input  logic [4:0]        dx_rd,
  input  logic              md_ready,
  input  logic              md_exception,
  input  logic [DATA_W-1:0] md_result,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic              stall_pipe,
  output logic              xm_md_valid,
  output logic [4:0]        xm_md_rd,
  output logic [DATA_W-1:0] xm_md_result,
  output logic              xm_md_exc,
  output logic              busy
);

  md_state_t           state;
  logic [4:0]          rd_q;
  logic [DATA_W-1:0]   result_q;
  logic                exc_q;
  logic [4:0]          xm_rd_q;
  logic [MD_CNT_W-1:0] cnt;
  logic                issue;
  logic                in_busy;
  logic                timeout;

  // Gating with reset keeps the start pulse and stall low while reset is held.
  assign issue   = (state == IDLE) && dx_valid && (dx_is_mult || dx_is_div) && !reset;
  assign in_busy = (state == BUSY);

`ifdef MD_TIMEOUT_EN
  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout = in_busy && (cnt == CNT_LAST);
`else
  logic cnt_unused;
  assign timeout    = 1'b0;
  assign cnt_unused = ^{cnt, TIMEOUT_CYCLES[0]};
`endif

  md_cycle_counter u_cycle_counter (
    .clock (clock),
    .reset (reset),
    .clr   (issue),
    .en    (in_busy),
    .cnt   (cnt)
  );

  assign md_ctrl_mult = issue && dx_is_mult;
  assign md_ctrl_div  = issue && !dx_is_mult;
  assign stall_pipe   = issue || in_busy;
  assign busy         = in_busy;
  assign xm_md_valid  = (state == DONE);
  assign xm_md_rd     = xm_rd_q;
  assign xm_md_result = result_q;
  assign xm_md_exc    = exc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rd_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      xm_rd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            rd_q  <= dx_rd;
            state <= BUSY;
          end
        end
        BUSY: begin
          // A real completion wins over a watchdog expiry in the same cycle.
          if (md_ready) begin
            result_q <= md_result;
            exc_q    <= md_exception;
            xm_rd_q  <= rd_q;
            state    <= DONE;
          end else if (timeout) begin
            result_q <= '0;
            exc_q    <= 1'b1;
            xm_rd_q  <= rd_q;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
